// File: rtl/aes_key_schedule_pkg.sv
// Shared types, per-size constants and GF(2^8) helpers for the AES key schedule.
// Sizes are encoded as the key_size port value: 0=128, 1=192, 2=256, 3=reserved.
package aes_ks_pkg;

  typedef enum logic [1:0] {
    KS_128  = 2'd0,
    KS_192  = 2'd1,
    KS_256  = 2'd2,
    KS_RSVD = 2'd3
  } key_size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_READY  = 2'd2
  } ks_state_e;

  localparam logic [3:0] NK_128 = 4'd4;
  localparam logic [3:0] NK_192 = 4'd6;
  localparam logic [3:0] NK_256 = 4'd8;
  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;
  localparam logic [5:0] TW_128 = 6'd44;
  localparam logic [5:0] TW_192 = 6'd52;
  localparam logic [5:0] TW_256 = 6'd60;
  localparam logic [7:0] RCON_INIT = 8'h01;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Reserved size maps to zero so callers can reject it with a single compare.
  function automatic logic [3:0] nk_of(input key_size_e sz);
    case (sz)
      KS_128:  return NK_128;
      KS_192:  return NK_192;
      KS_256:  return NK_256;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [5:0] tw_of(input key_size_e sz);
    case (sz)
      KS_128:  return TW_128;
      KS_192:  return TW_192;
      KS_256:  return TW_256;
      default: return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Key-load and round-key read bundle between the cipher datapath and the key schedule.
// master = cipher side (offers keys, issues reads); slave = schedule engine.
interface aes_key_schedule_if;
  logic [255:0] key_in;
  logic [1:0]   key_size;
  logic         key_vld;
  logic         key_rdy;
  logic         busy;
  logic         keys_valid;
  logic         done;
  logic         err;
  logic [3:0]   nr;
  logic         rk_rd_en;
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;

  modport master (
    output key_in, key_size, key_vld, rk_rd_en, rk_rd_idx,
    input  key_rdy, busy, keys_valid, done, err, nr, rk_rd_data
  );

  modport slave (
    input  key_in, key_size, key_vld, rk_rd_en, rk_rd_idx,
    output key_rdy, busy, keys_valid, done, err, nr, rk_rd_data
  );
endinterface

// File: rtl/aes_sub_word.sv
// SubWord over four S-boxes, with an optional RotWord in front of them.
// Combinational; rot selects RotWord for the i mod Nk == 0 step, else plain SubWord.
module aes_sub_word (
  input  logic [31:0] word,
  input  logic        rot,
  output logic [31:0] result
);

  logic [31:0] sbox_in;

  assign sbox_in = rot ? {word[23:0], word[31:24]} : word;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    sub_byte u_sbox (
      .val    (sbox_in[8*b +: 8]),
      .result (result[8*b +: 8])
    );
  end

endmodule

// File: rtl/sub_byte.sv
// AES forward S-box, one byte; purely combinational, no handshake.
// Table row r holds S(r*16 .. r*16+15), first entry in the most significant bits.
module sub_byte (
  input  logic [7:0] val,
  output logic [7:0] result
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign result = SBOX[val];

endmodule

// File: rtl/aes_key_schedule.sv
// Iterative AES-128/192/256 key schedule: one word per cycle, 40/46/52 cycles per key;
// key_rdy low while expanding, reads have 1-cycle latency. AES_KS_ZEROIZE_EN adds a zeroize port.
module aes_key_schedule
  import aes_ks_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic clk,
  input  logic rst_n,
`ifdef AES_KS_ZEROIZE_EN
  input  logic zeroize,
`endif
  aes_key_schedule_if.slave ks
);

  localparam logic [3:0] MAX_NK    = 4'(MAX_KEY_BITS / 32);
  localparam int         MAX_WORDS = 4 * (MAX_KEY_BITS / 32 + 7);

  logic zero_clr;
`ifdef AES_KS_ZEROIZE_EN
  assign zero_clr = zeroize;
`else
  assign zero_clr = 1'b0;
`endif

  ks_state_e   state;
  logic [31:0] w_buf [MAX_WORDS];
  logic [3:0]  nk_r;
  logic [5:0]  i_r;
  logic [5:0]  last_r;
  logic [2:0]  mod_r;
  logic [7:0]  rcon_r;

  key_size_e   size_in;
  logic [3:0]  nk_in;
  logic [5:0]  tw_in;
  logic        size_ok;
  logic        accept;

  assign size_in = key_size_e'(ks.key_size);
  assign nk_in   = nk_of(size_in);
  assign tw_in   = tw_of(size_in);
  assign size_ok = (size_in != KS_RSVD) && (nk_in <= MAX_NK);
  assign accept  = ks.key_vld && ks.key_rdy;

  // Next-word datapath: mod_r tracks i mod Nk so no divider is needed.
  logic [5:0]  prev_idx;
  logic [5:0]  back_idx;
  logic [31:0] prev_w;
  logic [31:0] back_w;
  logic        rot_sel;
  logic [31:0] sw_out;
  logic [31:0] temp;
  logic [31:0] new_w;
  logic        mod_wrap;

  assign prev_idx = i_r - 6'd1;
  assign back_idx = i_r - {2'b00, nk_r};
  assign prev_w   = w_buf[prev_idx];
  assign back_w   = w_buf[back_idx];
  assign rot_sel  = (mod_r == 3'd0);
  assign mod_wrap = ({1'b0, mod_r} == (nk_r - 4'd1));

  aes_sub_word u_sub_word (
    .word   (prev_w),
    .rot    (rot_sel),
    .result (sw_out)
  );

  always_comb begin
    temp = prev_w;
    if (rot_sel) begin
      temp = sw_out ^ {rcon_r, 24'h000000};
    end else if ((nk_r == NK_256) && (mod_r == 3'd4)) begin
      temp = sw_out;
    end
  end

  assign new_w = back_w ^ temp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      ks.key_rdy    <= 1'b1;
      ks.busy       <= 1'b0;
      ks.keys_valid <= 1'b0;
      ks.done       <= 1'b0;
      ks.err        <= 1'b0;
      ks.nr         <= 4'd0;
      nk_r          <= NK_128;
      i_r           <= 6'd0;
      last_r        <= 6'd0;
      mod_r         <= 3'd0;
      rcon_r        <= RCON_INIT;
    end else begin
      ks.done <= 1'b0;
      ks.err  <= 1'b0;
      if (zero_clr) begin
        state         <= ST_IDLE;
        ks.key_rdy    <= 1'b1;
        ks.busy       <= 1'b0;
        ks.keys_valid <= 1'b0;
        ks.nr         <= 4'd0;
      end else if (accept) begin
        ks.keys_valid <= 1'b0;
        ks.nr         <= 4'd0;
        if (size_ok) begin
          state      <= ST_EXPAND;
          ks.key_rdy <= 1'b0;
          ks.busy    <= 1'b1;
          nk_r       <= nk_in;
          i_r        <= {2'b00, nk_in};
          last_r     <= tw_in - 6'd1;
          mod_r      <= 3'd0;
          rcon_r     <= RCON_INIT;
        end else begin
          state  <= ST_IDLE;
          ks.err <= 1'b1;
        end
      end else if (state == ST_EXPAND) begin
        i_r   <= i_r + 6'd1;
        mod_r <= mod_wrap ? 3'd0 : mod_r + 3'd1;
        if (rot_sel) begin
          rcon_r <= xtime(rcon_r);
        end
        if (i_r == last_r) begin
          state         <= ST_READY;
          ks.key_rdy    <= 1'b1;
          ks.busy       <= 1'b0;
          ks.keys_valid <= 1'b1;
          ks.done       <= 1'b1;
          ks.nr         <= nk_r + 4'd6;
        end
      end
    end
  end

  // A rejected size leaves the buffer untouched; only a valid load or EXPAND writes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < MAX_WORDS; j++) begin
        w_buf[j] <= 32'h0;
      end
    end else if (zero_clr) begin
      for (int j = 0; j < MAX_WORDS; j++) begin
        w_buf[j] <= 32'h0;
      end
    end else if (accept && size_ok) begin
      for (int j = 0; j < 8; j++) begin
        if (4'(j) < nk_in) begin
          w_buf[j] <= ks.key_in[255 - 32*j -: 32];
        end
      end
    end else if (state == ST_EXPAND) begin
      w_buf[i_r] <= new_w;
    end
  end

  logic [5:0] rd_base;
  logic       rd_hit;

  assign rd_base = {ks.rk_rd_idx, 2'b00};
  assign rd_hit  = ks.keys_valid && (ks.rk_rd_idx <= ks.nr);

  // Uses the pre-edge keys_valid/nr, so a read alongside a new load sees the old schedule.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ks.rk_rd_data <= 128'h0;
    end else if (zero_clr) begin
      ks.rk_rd_data <= 128'h0;
    end else if (ks.rk_rd_en) begin
      if (rd_hit) begin
        ks.rk_rd_data <= {w_buf[rd_base], w_buf[rd_base + 6'd1],
                          w_buf[rd_base + 6'd2], w_buf[rd_base + 6'd3]};
      end else begin
        ks.rk_rd_data <= 128'h0;
      end
    end
  end

endmodule
